// File: rtl/bus_mem6502.sv
// bus_mem6502
//
// Memory and bus-recorder model for cpu6502 benches. It sits directly on the
// CPU address, data, rw and clk2 (phi2) pins. It provides:
//   - a writable RAM region at 0x0000 .. 2^RAM_AW-1;
//   - a preloadable ROM region at ROM_BASE .. ROM_BASE+2^ROM_AW-1, read-only
//     from the bus;
//   - fixed NMI/RESET/IRQ vectors at 0xFFFA..0xFFFF;
//   - a time-stamped FIFO log of every bus write, so benches can check
//     stores without probing CPU internals.
//
// Ports:
//   clk        in   bench clock, same clock that drives cpu6502
//   reset      in   synchronous, active-high reset
//   addr       in   CPU address bus
//   odata      in   CPU write data
//   rw         in   1 = read, 0 = write
//   clk2       in   CPU phi2 output
//   idata      out  combinational read data to the CPU
//   ld_en      in   bench preload strobe (RAM or ROM only)
//   ld_addr    in   preload address
//   ld_data    in   preload data
//   log_valid  out  log FIFO non-empty
//   log_pop    in   consume the head entry
//   log_cycle  out  head entry cycle stamp
//   log_addr   out  head entry address
//   log_data   out  head entry data
//   log_ro     out  head entry targeted read-only or unmapped space
//   log_count  out  number of entries held
//   log_ovf    out  sticky: a write was dropped because the log was full
//   cycle      out  free-running clk count

module bus_mem6502 #(
    parameter int          RAM_AW    = 11,
    parameter logic [15:0] ROM_BASE  = 16'h4000,
    parameter int          ROM_AW    = 12,
    parameter logic [15:0] NMI_VEC   = 16'h0000,
    parameter logic [15:0] RESET_VEC = 16'h0000,
    parameter logic [15:0] IRQ_VEC   = 16'h0000,
    parameter logic [7:0]  FILL      = 8'hff,
    parameter int          LOG_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [15:0]                  addr,
    input  logic [7:0]                   odata,
    input  logic                         rw,
    input  logic                         clk2,
    output logic [7:0]                   idata,
    input  logic                         ld_en,
    input  logic [15:0]                  ld_addr,
    input  logic [7:0]                   ld_data,
    output logic                         log_valid,
    input  logic                         log_pop,
    output logic [15:0]                  log_cycle,
    output logic [15:0]                  log_addr,
    output logic [7:0]                   log_data,
    output logic                         log_ro,
    output logic [$clog2(LOG_DEPTH):0]   log_count,
    output logic                         log_ovf,
    output logic [15:0]                  cycle
);

    localparam int          RAM_SIZE = 1 << RAM_AW;
    localparam int          ROM_SIZE = 1 << ROM_AW;
    localparam int          PW       = $clog2(LOG_DEPTH);
    localparam int          CW       = PW + 1;
    // Range ends are computed in 17 bits so a region touching 0xFFFF does
    // not wrap to zero.
    localparam logic [16:0] RAM_END  = 17'(RAM_SIZE);
    localparam logic [16:0] ROM_LO   = {1'b0, ROM_BASE};
    localparam logic [16:0] ROM_END  = ROM_LO + 17'(ROM_SIZE);
    localparam logic [CW-1:0] FULL_COUNT = CW'(LOG_DEPTH);

    logic [7:0] ramMem [RAM_SIZE];
    logic [7:0] romMem [ROM_SIZE];

    logic [15:0] logCycleMem [LOG_DEPTH];
    logic [15:0] logAddrMem  [LOG_DEPTH];
    logic [7:0]  logDataMem  [LOG_DEPTH];
    logic        logRoMem    [LOG_DEPTH];

    logic [15:0]   cycle_q;
    logic          clk2_q;
    logic [PW-1:0] wrPtr_q;
    logic [PW-1:0] rdPtr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          ovf_q;

    logic busVec, busRom, busRam;
    logic ldRom, ldRam;
    logic [RAM_AW-1:0] busRamIdx, ldRamIdx;
    logic [ROM_AW-1:0] busRomIdx, ldRomIdx;
    logic commit, logFull, popOk, pushOk;

    function automatic logic inRom(input logic [15:0] a);
        return ({1'b0, a} >= ROM_LO) && ({1'b0, a} < ROM_END);
    endfunction

    function automatic logic inRam(input logic [15:0] a);
        return {1'b0, a} < RAM_END;
    endfunction

    // Region decode with priority vectors > ROM > RAM > unmapped, shared by
    // the CPU bus and the preload port.
    always_comb begin
        busVec    = addr >= 16'hFFFA;
        busRom    = !busVec && inRom(addr);
        busRam    = !busVec && !busRom && inRam(addr);
        ldRom     = (ld_addr < 16'hFFFA) && inRom(ld_addr);
        ldRam     = (ld_addr < 16'hFFFA) && !ldRom && inRam(ld_addr);
        busRamIdx = RAM_AW'(addr);
        ldRamIdx  = RAM_AW'(ld_addr);
        busRomIdx = ROM_AW'(addr - ROM_BASE);
        ldRomIdx  = ROM_AW'(ld_addr - ROM_BASE);
    end

    // Read data is driven from addr alone, regardless of rw.
    always_comb begin
        idata = FILL;
        if (busVec) begin
            case (addr[2:0])
                3'b010:  idata = NMI_VEC[7:0];
                3'b011:  idata = NMI_VEC[15:8];
                3'b100:  idata = RESET_VEC[7:0];
                3'b101:  idata = RESET_VEC[15:8];
                3'b110:  idata = IRQ_VEC[7:0];
                3'b111:  idata = IRQ_VEC[15:8];
                default: idata = FILL;
            endcase
        end else if (busRom) begin
            idata = romMem[busRomIdx];
        end else if (busRam) begin
            idata = ramMem[busRamIdx];
        end
    end

    // A commit happens only on the first clk edge of a phi2 high phase, so a
    // long phi2 pulse still produces exactly one write and one log entry.
    // A full log accepts a push only when the head is popped on the same edge.
    always_comb begin
        commit  = clk2 && !clk2_q && !rw && !reset;
        logFull = count_q == FULL_COUNT;
        popOk   = log_pop && (count_q != '0);
        pushOk  = commit && (!logFull || popOk);
        count_d = count_q;
        case ({pushOk, popOk})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Arrays are never cleared by reset. The preload write is placed last so
    // it wins when both ports hit the same RAM byte on one edge.
    always_ff @(posedge clk) begin
        if (commit && busRam) begin
            ramMem[busRamIdx] <= odata;
        end
        if (ld_en && ldRam) begin
            ramMem[ldRamIdx] <= ld_data;
        end
        if (ld_en && ldRom) begin
            romMem[ldRomIdx] <= ld_data;
        end
    end

    // Log storage; ro marks any write that did not land in RAM.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            logCycleMem[wrPtr_q] <= cycle_q;
            logAddrMem[wrPtr_q]  <= addr;
            logDataMem[wrPtr_q]  <= odata;
            logRoMem[wrPtr_q]    <= !busRam;
        end
    end

    // Cycle counter, phi2 edge detector and log FIFO control.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q <= '0;
            clk2_q  <= 1'b0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cycle_q <= cycle_q + 16'd1;
            clk2_q  <= clk2;
            count_q <= count_d;
            if (pushOk) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (popOk) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            if (commit && !pushOk) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign log_valid = count_q != '0;
    assign log_count = count_q;
    assign log_ovf   = ovf_q;
    assign log_cycle = logCycleMem[rdPtr_q];
    assign log_addr  = logAddrMem[rdPtr_q];
    assign log_data  = logDataMem[rdPtr_q];
    assign log_ro    = logRoMem[rdPtr_q];
    assign cycle     = cycle_q;

endmodule

// File: tb/tb_bus_mem6502.sv
// Directed bench for bus_mem6502: decode/read paths, bus write commit and
// logging, log overflow and pop-while-full, long phi2 pulses, preload vs.
// commit collision, and reset behaviour.

module tb_bus_mem6502;

    logic        clk;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  odata;
    logic        rw;
    logic        clk2;
    logic [7:0]  idata;
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;
    logic        log_valid;
    logic        log_pop;
    logic [15:0] log_cycle;
    logic [15:0] log_addr;
    logic [7:0]  log_data;
    logic        log_ro;
    logic [2:0]  log_count;
    logic        log_ovf;
    logic [15:0] cycle;

    int          testCount = 0;
    int          failCount = 0;
    logic [15:0] expCycle;
    logic [15:0] stamp;
    logic [15:0] firstStamp;

    bus_mem6502 #(
        .RAM_AW    (11),
        .ROM_BASE  (16'h4000),
        .ROM_AW    (12),
        .NMI_VEC   (16'hABCD),
        .RESET_VEC (16'h1234),
        .IRQ_VEC   (16'h5678),
        .FILL      (8'hFF),
        .LOG_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .odata     (odata),
        .rw        (rw),
        .clk2      (clk2),
        .idata     (idata),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .log_valid (log_valid),
        .log_pop   (log_pop),
        .log_cycle (log_cycle),
        .log_addr  (log_addr),
        .log_data  (log_data),
        .log_ro    (log_ro),
        .log_count (log_count),
        .log_ovf   (log_ovf),
        .cycle     (cycle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cycle count: zero on a reset edge, +1 on every other edge.
    always @(posedge clk) begin
        if (reset) expCycle <= 16'd0;
        else       expCycle <= expCycle + 16'd1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkRead(input string tag, input logic [15:0] a,
                             input logic [7:0] expected);
        addr = a;
        rw   = 1'b1;
        #1;
        checkOutput(tag, {24'd0, idata}, {24'd0, expected});
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic popLog();
        log_pop = 1'b1;
        @(negedge clk);
        log_pop = 1'b0;
    endtask

    // One CPU write cycle: phi2 low, then phi2 high for 'highCycles' clks.
    // Optional pop/preload pulses line up with the commit edge.
    task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d,
                                 input int highCycles, input logic doPop,
                                 input logic doLd, input logic [15:0] la,
                                 input logic [7:0] lv, output logic [15:0] st);
        addr  = a;
        odata = d;
        rw    = 1'b0;
        clk2  = 1'b0;
        @(negedge clk);
        clk2    = 1'b1;
        log_pop = doPop;
        ld_en   = doLd;
        ld_addr = la;
        ld_data = lv;
        st      = expCycle;
        @(negedge clk);
        log_pop = 1'b0;
        ld_en   = 1'b0;
        for (int i = 1; i < highCycles; i++) @(negedge clk);
        clk2 = 1'b0;
        rw   = 1'b1;
    endtask

    task automatic checkHead(input string tag, input logic [15:0] a,
                             input logic [7:0] d, input logic ro,
                             input logic [15:0] st);
        checkOutput({tag, "_valid"}, {31'd0, log_valid}, 32'd1);
        checkOutput({tag, "_addr"},  {16'd0, log_addr},  {16'd0, a});
        checkOutput({tag, "_data"},  {24'd0, log_data},  {24'd0, d});
        checkOutput({tag, "_ro"},    {31'd0, log_ro},    {31'd0, ro});
        checkOutput({tag, "_cycle"}, {16'd0, log_cycle}, {16'd0, st});
    endtask

    initial begin
        reset   = 1'b1;
        addr    = 16'h0000;
        odata   = 8'h00;
        rw      = 1'b1;
        clk2    = 1'b0;
        ld_en   = 1'b0;
        ld_addr = 16'h0000;
        ld_data = 8'h00;
        log_pop = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_cycle", {16'd0, cycle}, 32'd0);
        checkOutput("rst_valid", {31'd0, log_valid}, 32'd0);
        checkOutput("rst_count", {29'd0, log_count}, 32'd0);
        checkOutput("rst_ovf",   {31'd0, log_ovf}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("cycle_1", {16'd0, cycle}, 32'd1);
        repeat (4) @(negedge clk);
        checkOutput("cycle_5", {16'd0, cycle}, 32'd5);

        // Preloads, including ignored vector/unmapped targets
        preload(16'h4480, 8'hC0);
        preload(16'h4FFF, 8'h77);
        preload(16'h0010, 8'h5A);
        preload(16'h0050, 8'h00);
        preload(16'hFFFC, 8'h99);
        preload(16'h8000, 8'h00);

        // Decode and read paths
        checkRead("vec_nmi_lo", 16'hFFFA, 8'hCD);
        checkRead("vec_nmi_hi", 16'hFFFB, 8'hAB);
        checkRead("vec_rst_lo", 16'hFFFC, 8'h34);
        checkRead("vec_rst_hi", 16'hFFFD, 8'h12);
        checkRead("vec_irq_lo", 16'hFFFE, 8'h78);
        checkRead("vec_irq_hi", 16'hFFFF, 8'h56);
        checkRead("unmap_8000", 16'h8000, 8'hFF);
        checkRead("rom_4480",   16'h4480, 8'hC0);
        checkRead("rom_last",   16'h4FFF, 8'h77);
        checkRead("rom_past",   16'h5000, 8'hFF);
        checkRead("below_rom",  16'h3FFF, 8'hFF);
        checkRead("ram_0010",   16'h0010, 8'h5A);
        checkRead("ram_past",   16'h0800, 8'hFF);
        @(negedge clk);

        // LDX #$80 / ORA $4400,X / STA $99: operand read then the store
        checkRead("ora_operand", 16'h4480, 8'hC0);
        @(negedge clk);
        applyStimulus(16'h0099, 8'hC0, 1, 1'b0, 1'b0, 16'h0000, 8'h00, stamp);
        checkRead("sta_ram", 16'h0099, 8'hC0);
        checkOutput("sta_count", {29'd0, log_count}, 32'd1);
        checkHead("sta_head", 16'h0099, 8'hC0, 1'b0, stamp);
        popLog();
        checkOutput("sta_popped", {31'd0, log_valid}, 32'd0);

        // Bus write into ROM is logged but does not change the array
        applyStimulus(16'h4480, 8'h55, 1, 1'b0, 1'b0, 16'h0000, 8'h00, stamp);
        checkRead("rom_kept", 16'h4480, 8'hC0);
        checkHead("rom_head", 16'h4480, 8'h55, 1'b1, stamp);
        popLog();

        // phi2 held high for three clks: one commit
        applyStimulus(16'h0020, 8'h11, 3, 1'b0, 1'b0, 16'h0000, 8'h00, stamp);
        @(negedge clk);
        checkOutput("long_count", {29'd0, log_count}, 32'd1);
        checkHead("long_head", 16'h0020, 8'h11, 1'b0, stamp);
        checkRead("long_ram", 16'h0020, 8'h11);
        popLog();
        checkOutput("long_empty", {29'd0, log_count}, 32'd0);

        // Five writes into a four-entry log
        applyStimulus(16'h0030, 8'hA0, 1, 1'b0, 1'b0, 16'h0000, 8'h00, firstStamp);
        applyStimulus(16'h0031, 8'hA1, 1, 1'b0, 1'b0, 16'h0000, 8'h00, stamp);
        applyStimulus(16'h0032, 8'hA2, 1, 1'b0, 1'b0, 16'h0000, 8'h00, stamp);
        applyStimulus(16'h0033, 8'hA3, 1, 1'b0, 1'b0, 16'h0000, 8'h00, stamp);
        checkOutput("full_noovf", {31'd0, log_ovf}, 32'd0);
        applyStimulus(16'h0034, 8'hA4, 1, 1'b0, 1'b0, 16'h0000, 8'h00, stamp);
        checkOutput("ovf_count", {29'd0, log_count}, 32'd4);
        checkOutput("ovf_flag",  {31'd0, log_ovf}, 32'd1);
        checkHead("ovf_head", 16'h0030, 8'hA0, 1'b0, firstStamp);

        // Sixth write with a simultaneous pop while full
        applyStimulus(16'h0035, 8'hA5, 1, 1'b1, 1'b0, 16'h0000, 8'h00, stamp);
        checkOutput("pushpop_count", {29'd0, log_count}, 32'd4);
        checkOutput("pushpop_addr",  {16'd0, log_addr}, 32'h0031);
        popLog();
        checkOutput("drain_addr2", {16'd0, log_addr}, 32'h0032);
        popLog();
        checkOutput("drain_addr3", {16'd0, log_addr}, 32'h0033);
        popLog();
        checkHead("sixth_head", 16'h0035, 8'hA5, 1'b0, stamp);
        checkOutput("sixth_count", {29'd0, log_count}, 32'd1);
        popLog();
        checkOutput("drained_valid", {31'd0, log_valid}, 32'd0);
        popLog();
        checkOutput("empty_pop", {29'd0, log_count}, 32'd0);
        checkOutput("ovf_sticky", {31'd0, log_ovf}, 32'd1);

        // Preload and bus commit hit the same RAM byte: preload wins
        applyStimulus(16'h0040, 8'h12, 1, 1'b0, 1'b1, 16'h0040, 8'hEE, stamp);
        checkRead("collide_ram", 16'h0040, 8'hEE);
        checkHead("collide_head", 16'h0040, 8'h12, 1'b0, stamp);
        applyStimulus(16'h0041, 8'h34, 1, 1'b0, 1'b0, 16'h0000, 8'h00, stamp);
        checkOutput("two_queued", {29'd0, log_count}, 32'd2);

        // Reset with two entries queued; a phi2 rise on the reset edge
        reset = 1'b1;
        addr  = 16'h0050;
        odata = 8'h77;
        rw    = 1'b0;
        clk2  = 1'b0;
        @(negedge clk);
        clk2 = 1'b1;
        @(negedge clk);
        checkOutput("rst2_count", {29'd0, log_count}, 32'd0);
        checkOutput("rst2_valid", {31'd0, log_valid}, 32'd0);
        checkOutput("rst2_cycle", {16'd0, cycle}, 32'd0);
        checkOutput("rst2_ovf",   {31'd0, log_ovf}, 32'd0);
        clk2  = 1'b0;
        reset = 1'b0;
        checkRead("rst2_nocommit", 16'h0050, 8'h00);
        checkRead("rst2_ram40",    16'h0040, 8'hEE);
        checkRead("rst2_ram99",    16'h0099, 8'hC0);
        @(negedge clk);
        checkOutput("post_rst_cycle", {16'd0, cycle}, 32'd1);
        checkOutput("post_rst_count", {29'd0, log_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
